// File: rtl/sat_mixer_pkg.sv
// sat_mixer_pkg: shared FSM state type and accumulator sizing helper for sat_mixer.
package sat_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } state_t;

  // One sign-growth bit for the gain (up to ~2x) plus log2(channels) for the sum.
  function automatic int unsigned acc_width(input int unsigned in_width,
                                            input int unsigned channels);
    return in_width + 32'd1 + unsigned'($clog2(channels));
  endfunction

endpackage

// File: rtl/sat_mixer_saturate.sv
// sat_mixer_saturate: combinational signed clamp from IN_WIDTH to OUT_WIDTH.
// Ports: din (signed input), value (clamped signed output), clip (1 when clamped).
module sat_mixer_saturate #(
  parameter int unsigned IN_WIDTH  = 13,
  parameter int unsigned OUT_WIDTH = 10
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] value,
  output logic                        clip
);

  if (IN_WIDTH > OUT_WIDTH) begin : g_narrow
    localparam logic signed [OUT_WIDTH-1:0] MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    logic fits;

    // Value fits when every bit above the output sign bit equals the input sign.
    always_comb begin
      fits = (din[IN_WIDTH-1:OUT_WIDTH-1] == {(IN_WIDTH-OUT_WIDTH+1){din[IN_WIDTH-1]}});
      clip = ~fits;
      if (fits) begin
        value = din[OUT_WIDTH-1:0];
      end else if (din[IN_WIDTH-1]) begin
        value = MIN_V;
      end else begin
        value = MAX_V;
      end
    end
  end else begin : g_wide
    assign value = OUT_WIDTH'(din);
    assign clip  = 1'b0;
  end

endmodule

// File: rtl/sat_mixer.sv
// sat_mixer: multi-channel gain-scaled mixer with saturating output.
// One channel is multiplied and accumulated per cycle, then the sum is clamped.
// Ports: CLK, RESET (async active-high), STB (start), IN (packed signed samples),
//        VOL (packed unsigned gains, unity = 2**(VOL_WIDTH-1)), BUSY, OUT,
//        OUT_VALID (one-cycle pulse), CLIP.
// Optional macro SAT_MIXER_CLIP_HOLD_EN: stretch CLIP over CLIP_HOLD clean frames.
module sat_mixer
  import sat_mixer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 10,
  parameter int unsigned OUT_WIDTH = 10,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned VOL_WIDTH = 8,
  parameter int unsigned CLIP_HOLD = 16
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            STB,
  input  logic [CHANNELS*IN_WIDTH-1:0]    IN,
  input  logic [CHANNELS*VOL_WIDTH-1:0]   VOL,
  output logic                            BUSY,
  output logic signed [OUT_WIDTH-1:0]     OUT,
  output logic                            OUT_VALID,
  output logic                            CLIP
);

  localparam int unsigned ACC_W  = acc_width(IN_WIDTH, CHANNELS);
  localparam int unsigned CNT_W  = $clog2(CHANNELS);
  localparam int unsigned PROD_W = IN_WIDTH + VOL_WIDTH + 1;
  localparam int unsigned SHIFT  = VOL_WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                ch_q, ch_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic [CHANNELS*IN_WIDTH-1:0]    in_q, in_d;
  logic [CHANNELS*VOL_WIDTH-1:0]   vol_q, vol_d;
  logic signed [OUT_WIDTH-1:0]     out_d;
  logic                            busy_d, valid_d, clip_d;

  logic [IN_WIDTH-1:0]             cur_in;
  logic [VOL_WIDTH-1:0]            cur_vol;
  logic signed [PROD_W-1:0]        prod, term;
  logic signed [ACC_W-1:0]         acc_sum;
  logic signed [OUT_WIDTH-1:0]     sat_val;
  logic                            sat_clip;

`ifdef SAT_MIXER_CLIP_HOLD_EN
  localparam int unsigned HOLD_W = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  // Select the latched sample and gain of the current channel.
  always_comb begin
    cur_in  = '0;
    cur_vol = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (ch_q == CNT_W'(k)) begin
        cur_in  = in_q[k*IN_WIDTH +: IN_WIDTH];
        cur_vol = vol_q[k*VOL_WIDTH +: VOL_WIDTH];
      end
    end
  end

  // Signed sample times unsigned gain, floor-scaled back to unity.
  always_comb begin
    prod    = $signed({{(VOL_WIDTH+1){cur_in[IN_WIDTH-1]}}, cur_in}) *
              $signed({{IN_WIDTH{1'b0}}, cur_vol});
    term    = prod >>> SHIFT;
    acc_sum = acc_q + ACC_W'(term);
  end

  sat_mixer_saturate #(
    .IN_WIDTH  (ACC_W),
    .OUT_WIDTH (OUT_WIDTH)
  ) SATURATE (
    .din   (acc_q),
    .value (sat_val),
    .clip  (sat_clip)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    in_d    = in_q;
    vol_d   = vol_q;
    out_d   = OUT;
    valid_d = 1'b0;
`ifdef SAT_MIXER_CLIP_HOLD_EN
    hold_d  = hold_q;
    clip_d  = (hold_q != '0);
`else
    clip_d  = CLIP;
`endif

    case (state_q)
      IDLE: begin
        if (STB) begin
          in_d    = IN;
          vol_d   = VOL;
          acc_d   = '0;
          ch_d    = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        if (ch_q == LAST_CH) begin
          state_d = SAT;
        end else begin
          ch_d = ch_q + CNT_W'(1);
        end
      end
      SAT: begin
        out_d   = sat_val;
        valid_d = 1'b1;
        state_d = IDLE;
`ifdef SAT_MIXER_CLIP_HOLD_EN
        if (sat_clip) begin
          clip_d = 1'b1;
          hold_d = HOLD_W'(CLIP_HOLD);
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end
`else
        clip_d = sat_clip;
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      acc_q     <= '0;
      in_q      <= '0;
      vol_q     <= '0;
      BUSY      <= 1'b0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      CLIP      <= 1'b0;
`ifdef SAT_MIXER_CLIP_HOLD_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      in_q      <= in_d;
      vol_q     <= vol_d;
      BUSY      <= busy_d;
      OUT       <= out_d;
      OUT_VALID <= valid_d;
      CLIP      <= clip_d;
`ifdef SAT_MIXER_CLIP_HOLD_EN
      hold_q    <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_sat_mixer.sv
// tb_sat_mixer: randomized scoreboard bench for sat_mixer (4 ch, 10-bit, 8-bit gain).
module tb_sat_mixer;

  localparam int CH = 4;
  localparam int IW = 10;
  localparam int OW = 10;
  localparam int VW = 8;
  localparam int HOLD = 2;
  localparam int LAT = CH + 1;   // edges from accept edge to OUT_VALID edge

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  STB;
  logic [CH*IW-1:0]      IN;
  logic [CH*VW-1:0]      VOL;
  logic                  BUSY;
  logic signed [OW-1:0]  OUT;
  logic                  OUT_VALID;
  logic                  CLIP;

  sat_mixer #(
    .IN_WIDTH (IW), .OUT_WIDTH (OW), .CHANNELS (CH), .VOL_WIDTH (VW), .CLIP_HOLD (HOLD)
  ) dut (
    .CLK (CLK), .RESET (RESET), .STB (STB), .IN (IN), .VOL (VOL),
    .BUSY (BUSY), .OUT (OUT), .OUT_VALID (OUT_VALID), .CLIP (CLIP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int out;
    bit clip;
    int vedge;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   free_at = 0;
  int   last_accept = -100;
  int   hold_m = 0;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Reference mix: floor-scaled products summed exactly, then clamped.
  function automatic int model_mix(input logic [CH*IW-1:0] iv, input logic [CH*VW-1:0] vv,
                                   output bit sat);
    int acc = 0;
    for (int k = 0; k < CH; k++) begin
      int s = int'($signed(iv[k*IW +: IW]));
      int v = int'(vv[k*VW +: VW]);
      acc += (s * v) >>> (VW - 1);
    end
    sat = 1'b0;
    if (acc > (2**(OW-1)) - 1) begin
      acc = (2**(OW-1)) - 1;
      sat = 1'b1;
    end else if (acc < -(2**(OW-1))) begin
      acc = -(2**(OW-1));
      sat = 1'b1;
    end
    return acc;
  endfunction

  function automatic logic [CH*IW-1:0] fill_in(input int v);
    logic [CH*IW-1:0] r;
    for (int k = 0; k < CH; k++) r[k*IW +: IW] = IW'(v);
    return r;
  endfunction

  function automatic logic [CH*VW-1:0] fill_vol(input int v);
    logic [CH*VW-1:0] r;
    for (int k = 0; k < CH; k++) r[k*VW +: VW] = VW'(v);
    return r;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Drive one cycle; the model decides acceptance from its own frame timing.
  task automatic cycle(input bit stb, input logic [CH*IW-1:0] iv, input logic [CH*VW-1:0] vv);
    exp_t e;
    bit   sat;
    @(negedge CLK);
    STB = stb;
    IN  = iv;
    VOL = vv;
    if (stb && !RESET && (edge_cnt + 1 >= free_at)) begin
      e.out = model_mix(iv, vv, sat);
`ifdef SAT_MIXER_CLIP_HOLD_EN
      if (sat) begin
        e.clip = 1'b1;
        hold_m = HOLD;
      end else begin
        e.clip = (hold_m != 0);
        if (hold_m > 0) hold_m--;
      end
`else
      e.clip = sat;
`endif
      e.vedge = edge_cnt + 1 + LAT;
      q.push_back(e);
      last_accept = edge_cnt + 1;
      free_at = edge_cnt + 1 + CH + 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, IN ^ CH*IW'($urandom), VOL ^ CH*VW'($urandom));
  endtask

  // Monitor: BUSY against model timing, outputs against scoreboard on OUT_VALID.
  always @(negedge CLK) begin
    bit busy_exp;
    exp_t e;
    busy_exp = (edge_cnt >= last_accept) && (edge_cnt <= last_accept + CH);
    check("busy", int'(BUSY), int'(busy_exp));
    if (OUT_VALID) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("valid_edge", edge_cnt, e.vedge);
        check("out", int'(OUT), e.out);
        check("clip", int'(CLIP), int'(e.clip));
      end
    end else if (q.size() != 0 && edge_cnt >= q[0].vedge) begin
      e = q.pop_front();
      check("missing_valid", 0, 1);
    end
  end

  initial begin
    logic [CH*IW-1:0] iv;
    logic [CH*VW-1:0] vv;

    RESET = 1'b1;
    STB   = 1'b0;
    IN    = '0;
    VOL   = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy", int'(BUSY), 0);
    check("reset_out", int'(OUT), 0);
    check("reset_valid", int'(OUT_VALID), 0);
    check("reset_clip", int'(CLIP), 0);
    RESET = 1'b0;

    // Directed frames: unity gain, both saturation rails, floor rounding.
    cycle(1'b1, fill_in(100), fill_vol(128));  idle(7);
    cycle(1'b1, fill_in(511), fill_vol(255));  idle(7);
    cycle(1'b1, fill_in(-512), fill_vol(128)); idle(7);
    iv = fill_in(0); vv = fill_vol(0);
    iv[IW-1:0] = IW'(-3);  vv[VW-1:0] = VW'(64);
    cycle(1'b1, iv, vv); idle(7);
    iv[IW-1:0] = IW'(300);
    cycle(1'b1, iv, vv); idle(7);

    // STB held high: frames every CH+2 cycles, random data changing while busy.
    for (int i = 0; i < 20; i++) cycle(1'b1, CH*IW'($urandom), CH*VW'($urandom));
    idle(8);

    // Clip then three clean frames.
    cycle(1'b1, fill_in(511), fill_vol(255)); idle(6);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, fill_in(10), fill_vol(128)); idle(6);
    end

    // Reset in mid-frame aborts it; STB right after release is accepted.
    cycle(1'b1, fill_in(50), fill_vol(128));
    idle(2);
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    q.delete();
    last_accept = -100;
    free_at = 0;
    hold_m = 0;
    #1;
    check("abort_busy", int'(BUSY), 0);
    check("abort_out", int'(OUT), 0);
    check("abort_valid", int'(OUT_VALID), 0);
    @(negedge CLK);
    RESET = 1'b0;
    cycle(1'b1, fill_in(-20), fill_vol(128)); idle(7);

    // Random traffic with random STB density and occasional extreme gains.
    for (int i = 0; i < 400; i++) begin
      iv = CH*IW'($urandom);
      vv = ($urandom_range(0, 3) == 0) ? fill_vol(255) : CH*VW'($urandom);
      cycle(1'($urandom_range(0, 2) == 0), iv, vv);
    end

    idle(12);
    check("drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sat_mixer.md
SAT_MIXER -- requirements
Module: sat_mixer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 10, signed sample width per channel.
REQ-002 SHALL have parameter OUT_WIDTH, default 10, signed output width.
REQ-003 SHALL have parameter CHANNELS, default 4, number of mixed channels (>=2).
REQ-004 SHALL have parameter VOL_WIDTH, default 8, unsigned per-channel gain width; unity gain = 2**(VOL_WIDTH-1).
REQ-005 SHALL have parameter CLIP_HOLD, default 16, number of output frames CLIP is stretched (used only with the Configuration macro).
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port CLK  input  1  clock, all state on rising edge.
REQ-008 SHALL have port RESET  input  1  asynchronous active-high reset.
REQ-009 SHALL have port STB  input  1  start request; samples IN and VOL when accepted.
REQ-010 SHALL have port IN  input  CHANNELS*IN_WIDTH  signed samples, channel k at bits [k*IN_WIDTH +: IN_WIDTH].
REQ-011 SHALL have port VOL  input  CHANNELS*VOL_WIDTH  unsigned gains, same packing as IN.
REQ-012 SHALL have port BUSY  output  1  high while a frame is in progress.
REQ-013 SHALL have port OUT  output  OUT_WIDTH  saturated signed mix, held between frames.
REQ-014 SHALL have port OUT_VALID  output  1  one-cycle pulse when OUT updates.
REQ-015 SHALL have port CLIP  output  1  clip indicator.

Function
REQ-016 SHALL implement states IDLE, ACCUM, SAT; BUSY = (state != IDLE), registered.
REQ-017 In IDLE, STB high SHALL latch IN and VOL, clear accumulator and channel counter, and enter ACCUM; STB is ignored in ACCUM and SAT, with no queuing.
REQ-018 In ACCUM, each cycle SHALL add (sext(IN[ch]) * VOL[ch]) >>> (VOL_WIDTH-1), arithmetic shift (floor), to the accumulator; ch increments from 0; after ch = CHANNELS-1 the block enters SAT.
REQ-019 Accumulator width SHALL be IN_WIDTH + 1 + clog2(CHANNELS) so that no intermediate sum wraps.
REQ-020 In SAT, the block SHALL register OUT = acc if acc fits in OUT_WIDTH signed, else 2**(OUT_WIDTH-1)-1 (acc>0) or -2**(OUT_WIDTH-1) (acc<0); it SHALL then assert OUT_VALID for the next cycle and return to IDLE.
REQ-021 Latency: STB accepted in cycle t SHALL give OUT_VALID high in cycle t+CHANNELS+2 only.
REQ-022 STB high in the OUT_VALID cycle SHALL be accepted, giving back-to-back frames every CHANNELS+2 cycles.
REQ-023 Latched IN/VOL SHALL be used for the whole frame; input changes during BUSY SHALL have no effect.
REQ-024 Without the Configuration macro, CLIP SHALL update with each OUT_VALID to 1 if that frame saturated, else 0.

Reset
REQ-025 While RESET is high, the block SHALL force state=IDLE, BUSY=0, OUT=0, OUT_VALID=0, CLIP=0, and clear the accumulator, counter and hold counter.
REQ-026 RESET during ACCUM or SAT SHALL abort the frame with no OUT_VALID; STB SHALL be accepted on the first edge after release.

Configuration
REQ-027 Macro SAT_MIXER_CLIP_HOLD_EN: when defined, a saturated frame SHALL set CLIP=1 and load the hold counter with CLIP_HOLD; each non-saturated OUT_VALID SHALL decrement it, and CLIP drops when it reaches 0; when undefined, REQ-024 applies and no hold counter is built.

Structure
REQ-028 Package sat_mixer_pkg SHALL hold the state enum typedef and a clog2-based accumulator-width function.
REQ-029 Saturation SHALL be a combinational sub-module SATURATE (params IN_WIDTH, OUT_WIDTH; outputs value and clip flag), instantiated once.

Verification (CHANNELS=4, IN_WIDTH=10, OUT_WIDTH=10, VOL_WIDTH=8, CLIP_HOLD=2)
REQ-030 All IN=100, VOL=128, STB at cycle 0 -> BUSY cycles 1-5, OUT_VALID at cycle 6 only, OUT=400, CLIP=0.
REQ-031 All IN=511, VOL=255 -> OUT=511, CLIP=1; all IN=-512, VOL=128 -> OUT=-512 (10'h200), CLIP=1.
REQ-032 IN0=-3, VOL0=64, other VOL=0 -> OUT=-2 (floor); IN0=300, VOL0=64 -> OUT=150.
REQ-033 STB held high continuously -> frames accepted at cycles 0, 6, 12; extra STB pulses during BUSY produce no extra OUT_VALID.
REQ-034 RESET asserted in cycle 3 of a frame -> no OUT_VALID, and OUT=0, BUSY=0 immediately.
REQ-035 With SAT_MIXER_CLIP_HOLD_EN: one clipping frame then three clean frames -> CLIP high through the 2nd clean OUT_VALID and low after it; without the macro -> low after the 1st clean frame.
